// File: rtl/spi_slave_pkg.sv
// Shared register map and STATUS/CTRL bit indices for the SPI master/slave pair.
// IRQ enable bit indices exist only when SPI_SLAVE_IRQ_EN is defined.
package spi_slave_pkg;

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_DATA_OUT = 4'd1;
  localparam logic [3:0] ADDR_DATA_IN  = 4'd2;
  localparam logic [3:0] ADDR_CTRL     = 4'd3;

  localparam int unsigned STAT_SEL      = 0;
  localparam int unsigned STAT_RX_FULL  = 1;
  localparam int unsigned STAT_OVERRUN  = 2;
  localparam int unsigned STAT_TX_EMPTY = 3;

  localparam int unsigned CTRL_CPHA = 0;
  localparam int unsigned CTRL_CPOL = 1;
  localparam int unsigned CTRL_EN   = 2;
`ifdef SPI_SLAVE_IRQ_EN
  localparam int unsigned CTRL_RXIE = 4;
  localparam int unsigned CTRL_TXIE = 5;
`endif

  function automatic logic [7:0] pack_status(input logic sel, input logic rx_full,
                                             input logic overrun, input logic tx_empty);
    logic [7:0] s;
    s = '0;
    s[STAT_SEL]      = sel;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_OVERRUN]  = overrun;
    s[STAT_TX_EMPTY] = tx_empty;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// RESET_VAL presets the chain so no spurious edge appears out of reset.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // One flop beyond the synchronizer holds the previous level for edge detection.
  logic [SYNC_STAGES:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {(SYNC_STAGES + 1){RESET_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  q_o & ~sync_q[SYNC_STAGES];
  assign fall_o = ~q_o &  sync_q[SYNC_STAGES];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint with a 4-register CPU bus, one-byte RX and TX buffers.
// Optional o_irq output and CTRL[5:4] interrupt enables under SPI_SLAVE_IRQ_EN.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_SCLK,
  input  logic       i_MOSI,
  output logic       o_MISO,
  output logic       o_MISO_oe,
  input  logic       i_SS_bar,
  input  logic       i_en,
  input  logic       i_wr,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic       o_irq
`endif
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] data_in_q, data_in_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rx_full_q, rx_full_d;
  logic       overrun_q, overrun_d;
  logic       tx_empty_q, tx_empty_d;
  logic [7:0] rdata_q, rdata_d;

  logic cpha, cpol, ctrl_en, selected;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load_tx, shift_tx, byte_done;
  logic cpu_rd, cpu_wr;
  logic [7:0] rx_byte, rd_mux;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i_SCLK),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i_SS_bar),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI has the same latency as SCLK so the sampled bit lines up with the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_MOSI};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign cpha     = ctrl_q[CTRL_CPHA];
  assign cpol     = ctrl_q[CTRL_CPOL];
  assign ctrl_en  = ctrl_q[CTRL_EN];
  assign selected = ~ss_s & ctrl_en;

  assign sclk_edge   = selected & (sclk_rise | sclk_fall);
  assign lead_edge   = sclk_edge & (sclk_s != cpol);
  assign trail_edge  = sclk_edge & (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;

  // A shift edge at count 0 starts a byte: for CPHA=1 that is every byte, for
  // CPHA=0 it is the trailing edge after a completed byte (back-to-back frames).
  assign load_tx   = (ss_fall & ctrl_en & ~cpha) | (shift_edge & (bit_cnt_q == 3'd0));
  assign shift_tx  = shift_edge & (bit_cnt_q != 3'd0);
  assign byte_done = sample_edge & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, mosi_s};

  assign cpu_rd = i_en & ~i_wr;
  assign cpu_wr = i_en &  i_wr;

  always_comb begin
    rd_mux = '0;
    case (i_addr)
      ADDR_STATUS:   rd_mux = pack_status(selected, rx_full_q, overrun_q, tx_empty_q);
      ADDR_DATA_OUT: rd_mux = tx_buf_q;
      ADDR_DATA_IN:  rd_mux = data_in_q;
      ADDR_CTRL:     rd_mux = ctrl_q;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    data_in_d  = data_in_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_full_d  = rx_full_q;
    overrun_d  = overrun_q;
    tx_empty_d = tx_empty_q;
    rdata_d    = rdata_q;

    if (cpu_rd) rdata_d = rd_mux;

    if (!selected)        bit_cnt_d = '0;
    else if (sample_edge) bit_cnt_d = bit_cnt_q + 3'd1;

    if (sample_edge) rx_shift_d = rx_byte[6:0];

    if (ss_rise)       tx_shift_d = 8'hFF;
    else if (load_tx)  tx_shift_d = tx_empty_q ? 8'hFF : tx_buf_q;
    else if (shift_tx) tx_shift_d = {tx_shift_q[6:0], 1'b1};

    if (load_tx) tx_empty_d = 1'b1;

    if (cpu_rd && i_addr == ADDR_DATA_IN) rx_full_d = 1'b0;
    if (cpu_wr && i_addr == ADDR_STATUS && i_data[STAT_OVERRUN]) overrun_d = 1'b0;

    // Completion is applied after CPU clears so it wins on a same-cycle collision.
    if (byte_done) begin
      if (!rx_full_q) begin
        data_in_d = rx_byte;
        rx_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (cpu_wr && i_addr == ADDR_DATA_OUT) begin
      tx_buf_d   = i_data;
      tx_empty_d = 1'b0;
    end
    if (cpu_wr && i_addr == ADDR_CTRL) ctrl_d = i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q     <= '0;
      data_in_q  <= '0;
      tx_buf_q   <= '1;
      tx_shift_q <= '1;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      data_in_q  <= data_in_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
      tx_empty_q <= tx_empty_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_MISO    = tx_shift_q[7];
  assign o_MISO_oe = selected;
  assign o_data    = rdata_q;

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) irq_q <= 1'b0;
    else       irq_q <= (rx_full_q & ctrl_q[CTRL_RXIE]) |
                        (tx_empty_q & ctrl_q[CTRL_TXIE] & selected);
  end
  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: behavioural SPI master plus a byte-level
// model of the slave's buffers and flags.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int H = 5;  // SCLK half period in i_clk cycles

  logic clk = 1'b0;
  logic rst, sclk, mosi, ss_bar, en, wr;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;
  logic miso, miso_oe;

  int n_pass = 0;
  int n_total = 0;

  // Byte-level model state
  logic [7:0] m_ctrl, m_data_in, m_tx_buf, m_exp_tx;
  logic       m_rx_full, m_ovr, m_tx_empty;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst(rst), .i_SCLK(sclk), .i_MOSI(mosi), .o_MISO(miso),
    .o_MISO_oe(miso_oe), .i_SS_bar(ss_bar), .i_en(en), .i_wr(wr),
    .i_addr(addr), .i_data(wdata), .o_data(rdata)
  );

  task automatic mdl_reset();
    m_ctrl = 8'h00; m_data_in = 8'h00; m_tx_buf = 8'hFF; m_exp_tx = 8'hFF;
    m_rx_full = 1'b0; m_ovr = 1'b0; m_tx_empty = 1'b1;
  endtask

  // A byte start hands out the buffered byte, or all-ones when nothing was queued.
  task automatic mdl_load();
    m_exp_tx = m_tx_empty ? 8'hFF : m_tx_buf;
    m_tx_empty = 1'b1;
  endtask

  task automatic mdl_recv(input logic [7:0] b);
    if (!m_rx_full) begin
      m_data_in = b;
      m_rx_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  function automatic logic [7:0] mdl_status(input logic sel);
    return {4'h0, m_tx_empty, m_ovr, m_rx_full, sel};
  endfunction

  task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
    if (a == ADDR_CTRL) m_ctrl = d;
    if (a == ADDR_DATA_OUT) begin
      m_tx_buf = d;
      m_tx_empty = 1'b0;
    end
    if (a == ADDR_STATUS && d[2]) m_ovr = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    d = rdata;
    if (a == ADDR_DATA_IN) m_rx_full = 1'b0;
  endtask

  task automatic set_mode(input int unsigned mode);
    logic [7:0] c, got;
    c = {3'($urandom), 2'($urandom), 1'b1, mode[1], mode[0]};
    reg_wr(ADDR_CTRL, c);
    sclk = c[1];
    repeat (4) @(negedge clk);
    reg_rd(ADDR_CTRL, got);
    n_total++;
    if (got !== c) $display("FAIL ctrl_readback: got %02h expected %02h", got, c);
    else n_pass++;
  endtask

  task automatic spi_select();
    ss_bar = 1'b0;
    if (!m_ctrl[0]) mdl_load();
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_deselect();
    repeat (H) @(negedge clk);
    ss_bar = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Master side of one (possibly partial) byte; exp is the MISO byte the model predicts.
  task automatic spi_byte(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic [7:0] exp);
    logic cpol, cpha;
    cpol = m_ctrl[1];
    cpha = m_ctrl[0];
    rx = 8'h00;
    if (cpha) mdl_load();
    exp = m_exp_tx;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        repeat (H) @(negedge clk);
        sclk = ~cpol;
        rx = {rx[6:0], miso};
        repeat (H) @(negedge clk);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = tx[7-i];
        repeat (H) @(negedge clk);
        sclk = cpol;
        rx = {rx[6:0], miso};
        repeat (H) @(negedge clk);
      end
    end
    if (nbits == 8) begin
      mdl_recv(tx);
      if (!cpha) mdl_load();
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    n_total++;
    if (rdata !== 8'h00) $display("FAIL reset_o_data: got %02h expected 00", rdata); else n_pass++;
    n_total++;
    if (miso !== 1'b1) $display("FAIL reset_miso: got %b expected 1", miso); else n_pass++;
    n_total++;
    if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); else n_pass++;
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0)) $display("FAIL reset_status: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
    reg_rd(ADDR_DATA_OUT, d);
    n_total++;
    if (d !== m_tx_buf) $display("FAIL reset_tx_buf: got %02h expected %02h", d, m_tx_buf); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
    n_total++;
    if (d !== m_data_in) $display("FAIL reset_data_in: got %02h expected %02h", d, m_data_in); else n_pass++;
    reg_wr(4'd7, 8'h5A);
    reg_rd(4'd7, d);
    n_total++;
    if (d !== 8'h00) $display("FAIL unused_addr: got %02h expected 00", d); else n_pass++;
  endtask

  task automatic test_mode0();
    logic [7:0] rx, exp, d;
    set_mode(0);
    reg_wr(ADDR_DATA_OUT, 8'hA5);
    spi_select();
    spi_byte(8'h3C, 8, rx, exp);
    n_total++;
    if (rx !== 8'hA5 || rx !== exp) $display("FAIL mode0_miso: got %02h expected %02h", rx, exp); else n_pass++;
    n_total++;
    if (miso_oe !== 1'b1) $display("FAIL mode0_oe: got %b expected 1", miso_oe); else n_pass++;
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b1)) $display("FAIL mode0_status_sel: got %02h expected %02h", d, mdl_status(1'b1)); else n_pass++;
    spi_deselect();
    n_total++;
    if (miso_oe !== 1'b0) $display("FAIL mode0_oe_off: got %b expected 0", miso_oe); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
    n_total++;
    if (d !== 8'h3C || d !== m_data_in) $display("FAIL mode0_data_in: got %02h expected %02h", d, m_data_in); else n_pass++;
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0)) $display("FAIL mode0_status_idle: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
  endtask

  task automatic test_modes();
    logic [7:0] rx, exp, d;
    for (int m = 1; m < 4; m++) begin
      set_mode(m);
      reg_wr(ADDR_DATA_OUT, 8'h81);
      spi_select();
      spi_byte(8'h7E, 8, rx, exp);
      spi_deselect();
      n_total++;
      if (rx !== 8'h81 || rx !== exp) $display("FAIL mode%0d_miso: got %02h expected %02h", m, rx, exp); else n_pass++;
      reg_rd(ADDR_DATA_IN, d);
      n_total++;
      if (d !== 8'h7E) $display("FAIL mode%0d_data_in: got %02h expected 7e", m, d); else n_pass++;
      reg_rd(ADDR_STATUS, d);
      n_total++;
      if (d !== mdl_status(1'b0)) $display("FAIL mode%0d_status: got %02h expected %02h", m, d, mdl_status(1'b0)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx, exp, d, b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    set_mode($urandom_range(0, 3));
    reg_wr(ADDR_DATA_OUT, 8'($urandom));
    spi_select();
    spi_byte(b0, 8, rx, exp);
    n_total++;
    if (rx !== exp) $display("FAIL b2b_miso0: got %02h expected %02h", rx, exp); else n_pass++;
    spi_byte(b1, 8, rx, exp);
    n_total++;
    if (rx !== exp) $display("FAIL b2b_miso1: got %02h expected %02h", rx, exp); else n_pass++;
    spi_deselect();
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0) || d[2] !== 1'b1) $display("FAIL b2b_overrun: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
    n_total++;
    if (d !== b0) $display("FAIL b2b_data_in: got %02h expected %02h", d, b0); else n_pass++;
    reg_wr(ADDR_STATUS, 8'h04);
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0)) $display("FAIL b2b_ovr_clear: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
  endtask

  task automatic test_tx_empty();
    logic [7:0] rx, exp, d;
    set_mode($urandom_range(0, 3));
    spi_select();
    spi_byte(8'($urandom), 8, rx, exp);
    spi_deselect();
    n_total++;
    if (rx !== 8'hFF) $display("FAIL txe_miso: got %02h expected ff", rx); else n_pass++;
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d[3] !== 1'b1 || d !== mdl_status(1'b0)) $display("FAIL txe_status: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
  endtask

  task automatic test_abort();
    logic [7:0] rx, exp, d;
    set_mode(0);
    reg_wr(ADDR_DATA_OUT, 8'($urandom));
    spi_select();
    spi_byte(8'($urandom), 5, rx, exp);
    ss_bar = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    n_total++;
    if (miso_oe !== 1'b0) $display("FAIL abort_oe: got %b expected 0", miso_oe); else n_pass++;
    repeat (H) @(negedge clk);
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0)) $display("FAIL abort_status: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
    spi_select();
    spi_byte(8'h55, 8, rx, exp);
    spi_deselect();
    n_total++;
    if (rx !== exp) $display("FAIL abort_miso: got %02h expected %02h", rx, exp); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
    n_total++;
    if (d !== 8'h55) $display("FAIL abort_data_in: got %02h expected 55", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] rx, exp, d, e;
    int nb;
    repeat (8) begin
      set_mode($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) reg_wr(ADDR_DATA_OUT, 8'($urandom));
      nb = $urandom_range(1, 2);
      spi_select();
      for (int b = 0; b < nb; b++) begin
        spi_byte(8'($urandom), 8, rx, exp);
        n_total++;
        if (rx !== exp) $display("FAIL rand_miso: got %02h expected %02h", rx, exp); else n_pass++;
      end
      spi_deselect();
      if ($urandom_range(0, 1) == 1) begin
        e = m_data_in;
        reg_rd(ADDR_DATA_IN, d);
        n_total++;
        if (d !== e) $display("FAIL rand_data_in: got %02h expected %02h", d, e); else n_pass++;
      end
      reg_rd(ADDR_STATUS, d);
      n_total++;
      if (d !== mdl_status(1'b0)) $display("FAIL rand_status: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
      if (m_ovr) reg_wr(ADDR_STATUS, 8'h04);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rx, exp, d, b;
    set_mode(0);
    reg_wr(ADDR_DATA_OUT, 8'h00);
    spi_select();
    spi_byte(8'($urandom), 3, rx, exp);
    reg_rd(ADDR_CTRL, d);
    n_total++;
    if (miso !== 1'b0 || miso_oe !== 1'b1) $display("FAIL pre_reset_pins: got %b%b expected 01", miso, miso_oe); else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (rdata !== 8'h00) $display("FAIL async_rst_o_data: got %02h expected 00", rdata); else n_pass++;
    n_total++;
    if (miso !== 1'b1 || miso_oe !== 1'b0) $display("FAIL async_rst_pins: got %b%b expected 10", miso, miso_oe); else n_pass++;
    @(negedge clk);
    ss_bar = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    reg_rd(ADDR_STATUS, d);
    n_total++;
    if (d !== mdl_status(1'b0)) $display("FAIL async_rst_status: got %02h expected %02h", d, mdl_status(1'b0)); else n_pass++;
    b = 8'($urandom);
    set_mode($urandom_range(0, 3));
    reg_wr(ADDR_DATA_OUT, 8'($urandom));
    spi_select();
    spi_byte(b, 8, rx, exp);
    spi_deselect();
    n_total++;
    if (rx !== exp) $display("FAIL post_rst_miso: got %02h expected %02h", rx, exp); else n_pass++;
    reg_rd(ADDR_DATA_IN, d);
    n_total++;
    if (d !== b) $display("FAIL post_rst_data_in: got %02h expected %02h", d, b); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_bar = 1'b1;
    en = 1'b0; wr = 1'b0; addr = 4'h0; wdata = 8'h00;
    mdl_reset();
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_tx_empty();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
